// File: rtl/cu_shift_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : cu_shift_issue_if
// Brief    : Instruction offer handshake between fetch and the shift issue stage
// Revision : 1.0 - initial release
// ============================================================================
interface cu_shift_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface
`default_nettype wire

// File: rtl/cu_shift_issue.sv
`default_nettype none
// ============================================================================
// Module   : cu_shift_issue
// Brief    : Issue/writeback stage for Thumb shift/move ops; owns r0-r7 and APSR
// Revision : 1.0 - initial release
// ============================================================================
module cu_shift_issue #(
    parameter int ALU_LATENCY = 1
) (
    input  wire                  clk,
    input  wire                  rst,
    cu_shift_issue_if.slave      ibus,
    output logic                 cu_execute,
    output logic [4:0]           instrution,
    output logic [31:0]          alu_rm,
    output logic [7:0]           alu_rs,
    output logic [4:0]           imm_shift,
    output logic                 IMM,
    output logic                 S,
    output logic [1:0]           stype,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    input  wire  [31:0]          alu_rd,
    input  wire                  alu_n,
    input  wire                  alu_z,
    input  wire                  alu_c,
    output logic                 retire,
    output logic                 illegal,
    input  wire  [2:0]           dbg_addr,
    output logic [31:0]          dbg_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [2:0] c_CNT_INIT = 3'(ALU_LATENCY - 1);
    localparam logic [4:0] c_OP_MOV_LAS = 5'h08;
    localparam logic [4:0] c_OP_NONE    = 5'h1f;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_rd;
    logic [31:0] r_regs [8];
    logic        r_n, r_z, r_c, r_v;
    logic        r_cu_execute;
    logic        r_retire;
    logic        r_illegal;
    logic [4:0]  r_instrution;
    logic [31:0] r_alu_rm;
    logic [7:0]  r_alu_rs;
    logic [4:0]  r_imm_shift;
    logic        r_imm;
    logic [1:0]  r_stype;

    logic        w_legal;
    logic [31:0] w_rm;
    logic [7:0]  w_rs;
    logic [4:0]  w_shamt;
    logic        w_imm;
    logic [1:0]  w_stype;
    logic [2:0]  w_rd;

    always_comb begin
        w_legal = 1'b0;
        w_rm    = '0;
        w_rs    = '0;
        w_shamt = '0;
        w_imm   = 1'b0;
        w_stype = 2'd0;
        w_rd    = ibus.instr[2:0];
        case (ibus.instr[15:11])
            5'b00000, 5'b00001, 5'b00010: begin
                w_legal = 1'b1;
                w_rm    = r_regs[ibus.instr[5:3]];
                w_stype = ibus.instr[12:11];
                // LSR/ASR #0 means a 32-bit shift, which imm_shift cannot express
                if (ibus.instr[10:6] == 5'd0 && ibus.instr[12:11] != 2'd0) begin
                    w_rs = 8'd32;
                end else begin
                    w_imm   = 1'b1;
                    w_shamt = ibus.instr[10:6];
                end
            end
            5'b00100: begin
                w_legal = 1'b1;
                w_rm    = {24'd0, ibus.instr[7:0]};
                w_imm   = 1'b1;
                w_rd    = ibus.instr[10:8];
            end
            5'b01000: begin
                if (ibus.instr[10:9] == 2'b00) begin
                    w_rm = r_regs[ibus.instr[2:0]];
                    w_rs = r_regs[ibus.instr[5:3]][7:0];
                    case (ibus.instr[8:6])
                        3'b010:  begin w_legal = 1'b1; w_stype = 2'd0; end
                        3'b011:  begin w_legal = 1'b1; w_stype = 2'd1; end
                        3'b100:  begin w_legal = 1'b1; w_stype = 2'd2; end
                        3'b111:  begin w_legal = 1'b1; w_stype = 2'd3; end
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_rd         <= 3'd0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            {r_n, r_z, r_c, r_v} <= 4'd0;
            r_cu_execute <= 1'b0;
            r_retire     <= 1'b0;
            r_illegal    <= 1'b0;
            r_instrution <= c_OP_NONE;
            r_alu_rm     <= '0;
            r_alu_rs     <= '0;
            r_imm_shift  <= '0;
            r_imm        <= 1'b0;
            r_stype      <= 2'd0;
        end else begin
            r_cu_execute <= 1'b0;
            r_retire     <= 1'b0;
            r_illegal    <= 1'b0;
            r_instrution <= c_OP_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (ibus.instr_valid) begin
                        if (w_legal) begin
                            r_alu_rm     <= w_rm;
                            r_alu_rs     <= w_rs;
                            r_imm_shift  <= w_shamt;
                            r_imm        <= w_imm;
                            r_stype      <= w_stype;
                            r_rd         <= w_rd;
                            r_cu_execute <= 1'b1;
                            r_instrution <= c_OP_MOV_LAS;
                            r_state      <= ST_EXEC;
                        end else begin
                            r_illegal <= 1'b1;
                            r_state   <= ST_ERR;
                        end
                    end
                end
                ST_EXEC: begin
                    if (ALU_LATENCY == 1) begin
                        r_retire <= 1'b1;
                        r_state  <= ST_WB;
                    end else begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_retire <= 1'b1;
                        r_state  <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WB: begin
                    // V is not produced by shifts/moves and keeps its value
                    r_regs[r_rd] <= alu_rd;
                    r_n          <= alu_n;
                    r_z          <= alu_z;
                    r_c          <= alu_c;
                    r_state      <= ST_IDLE;
                end
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ibus.instr_ready = (r_state == ST_IDLE);
    assign cu_execute       = r_cu_execute;
    assign instrution       = r_instrution;
    assign alu_rm           = r_alu_rm;
    assign alu_rs           = r_alu_rs;
    assign imm_shift        = r_imm_shift;
    assign IMM              = r_imm;
    assign S                = 1'b1;
    assign stype            = r_stype;
    assign flag_n           = r_n;
    assign flag_z           = r_z;
    assign flag_c           = r_c;
    assign flag_v           = r_v;
    assign retire           = r_retire;
    assign illegal          = r_illegal;
    assign dbg_data         = r_regs[dbg_addr];

endmodule
`default_nettype wire
